sprite_move_ctrl: RTL and testbench

Frame-synchronous controller that sequences position updates for the on-screen sprite. It decodes PS/2 scan-code bytes into move commands and queues them. It applies at most one command per video frame, at the start of vertical sync, so the displayed position never changes mid-frame. It clamps the position to the visible area and drives the x/y origin consumed by the pixel-enable compare in the VGA datapath.

---
 rtl/sprite_ctrl_pkg.sv | 41 ++++
 rtl/cmd_fifo.sv | 63 ++++++
 rtl/sprite_move_ctrl.sv | 110 +++++++++++
 tb/tb_sprite_move_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sprite_ctrl_pkg.sv
// rtl/sprite_ctrl_pkg.sv - scan codes, direction/decoder encodings and clamp helper for sprite_move_ctrl
package sprite_ctrl_pkg;

  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_BRK   = 8'hF0;
  localparam logic [7:0] KEY_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic {
    DEC_IDLE = 1'b0,
    DEC_BRK  = 1'b1
  } dec_state_e;

  // Saturating step in 11 bits so neither the add nor the subtract can wrap.
  function automatic logic [9:0] step_clamp(input logic [9:0]  pos,
                                            input logic        inc,
                                            input logic [10:0] step,
                                            input logic [10:0] lim);
    logic [10:0] p;
    logic [10:0] r;
    p = {1'b0, pos};
    if (inc) begin
      r = p + step;
      if (r > lim) r = lim;
    end else begin
      if (p < step) r = '0;
      else          r = p - step;
    end
    return 10'(r);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - synchronous FIFO holding queued move commands
module cmd_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

  // A pop frees the slot in the same cycle, so a push into a full FIFO is accepted alongside it.
  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sprite_move_ctrl.sv
// rtl/sprite_move_ctrl.sv - decodes PS/2 arrow keys and applies one clamped sprite move per frame
module sprite_move_ctrl
  import sprite_ctrl_pkg::*;
#(
  parameter int MOVE_STEP = 10,
  parameter int X_INIT    = 320,
  parameter int Y_INIT    = 240,
  parameter int X_MAX     = 575,
  parameter int Y_MAX     = 431,
  parameter int QDEPTH    = 4
) (
  input  logic                      iVGA_CLK,
  input  logic                      rst,
  input  logic [7:0]                key_in,
  input  logic                      key_en,
  input  logic                      iVS,
  output logic [9:0]                pos_x,
  output logic [9:0]                pos_y,
  output logic                      frame_tick,
  output logic                      cmd_drop,
  output logic [$clog2(QDEPTH):0]   cmd_count
);

  dec_state_e dec_state_q, dec_state_d;
  logic       vs_q, vs_d;
  logic       frame_tick_q, frame_tick_d;
  logic       cmd_drop_q, cmd_drop_d;
  logic [9:0] pos_x_q, pos_x_d;
  logic [9:0] pos_y_q, pos_y_d;

  logic       push, pop;
  dir_e       push_dir;
  logic [1:0] fifo_dout;
  logic       fifo_full, fifo_empty;

  cmd_fifo #(.WIDTH(2), .DEPTH(QDEPTH)) u_fifo (
    .clk   (iVGA_CLK),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (push_dir),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (cmd_count)
  );

  always_comb begin
    dec_state_d = dec_state_q;
    push        = 1'b0;
    push_dir    = DIR_UP;
    if (key_en) begin
      case (dec_state_q)
        DEC_IDLE: begin
          case (key_in)
            KEY_BRK:   dec_state_d = DEC_BRK;
            KEY_UP:    begin push = 1'b1; push_dir = DIR_UP;    end
            KEY_DOWN:  begin push = 1'b1; push_dir = DIR_DOWN;  end
            KEY_LEFT:  begin push = 1'b1; push_dir = DIR_LEFT;  end
            KEY_RIGHT: begin push = 1'b1; push_dir = DIR_RIGHT; end
            default:   ;
          endcase
        end
        // The byte after a break code is the released key; it never moves the sprite.
        DEC_BRK: if (key_in != KEY_EXT) dec_state_d = DEC_IDLE;
        default: dec_state_d = DEC_IDLE;
      endcase
    end

    vs_d         = iVS;
    frame_tick_d = vs_q & ~iVS;
    pop          = frame_tick_q & ~fifo_empty;
    cmd_drop_d   = push & fifo_full & ~pop;

    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    if (pop) begin
      case (fifo_dout)
        DIR_UP:    pos_y_d = step_clamp(pos_y_q, 1'b0, 11'(MOVE_STEP), 11'(Y_MAX));
        DIR_DOWN:  pos_y_d = step_clamp(pos_y_q, 1'b1, 11'(MOVE_STEP), 11'(Y_MAX));
        DIR_LEFT:  pos_x_d = step_clamp(pos_x_q, 1'b0, 11'(MOVE_STEP), 11'(X_MAX));
        default:   pos_x_d = step_clamp(pos_x_q, 1'b1, 11'(MOVE_STEP), 11'(X_MAX));
      endcase
    end
  end

  always_ff @(posedge iVGA_CLK) begin
    if (rst) begin
      dec_state_q  <= DEC_IDLE;
      vs_q         <= 1'b1;
      frame_tick_q <= 1'b0;
      cmd_drop_q   <= 1'b0;
      pos_x_q      <= 10'(X_INIT);
      pos_y_q      <= 10'(Y_INIT);
    end else begin
      dec_state_q  <= dec_state_d;
      vs_q         <= vs_d;
      frame_tick_q <= frame_tick_d;
      cmd_drop_q   <= cmd_drop_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
    end
  end

  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign frame_tick = frame_tick_q;
  assign cmd_drop   = cmd_drop_q;

endmodule

// File: tb/tb_sprite_move_ctrl.sv
// tb/tb_sprite_move_ctrl.sv - scoreboard bench for sprite_move_ctrl
module tb_sprite_move_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] key_in;
  logic       key_en;
  logic       iVS;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic       frame_tick;
  logic       cmd_drop;
  logic [2:0] cmd_count;

  int total = 0;
  int bad   = 0;

  int mx, my;
  bit brk;
  int sb[$];

  sprite_move_ctrl dut (
    .iVGA_CLK   (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_en     (key_en),
    .iVS        (iVS),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .frame_tick (frame_tick),
    .cmd_drop   (cmd_drop),
    .cmd_count  (cmd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mx = 320;
    my = 240;
    brk = 0;
    sb.delete();
  endtask

  task automatic model_apply(input int d);
    case (d)
      0: begin my = my - 10; if (my < 0) my = 0; end
      1: begin my = my + 10; if (my > 431) my = 431; end
      2: begin mx = mx - 10; if (mx < 0) mx = 0; end
      default: begin mx = mx + 10; if (mx > 575) mx = 575; end
    endcase
  endtask

  task automatic model_key(input logic [7:0] k, output bit drop);
    int d;
    drop = 0;
    d = -1;
    if (brk) begin
      if (k != 8'hE0) brk = 0;
    end else begin
      case (k)
        8'hF0: brk = 1;
        8'h75: d = 0;
        8'h72: d = 1;
        8'h6B: d = 2;
        8'h74: d = 3;
        default: ;
      endcase
    end
    if (d >= 0) begin
      if (sb.size() >= 4) drop = 1;
      else sb.push_back(d);
    end
  endtask

  task automatic send_key(input logic [7:0] k);
    bit drop;
    model_key(k, drop);
    key_in = k;
    key_en = 1'b1;
    tick();
    key_en = 1'b0;
    chk("key_drop", 32'(cmd_drop), 32'(drop));
    chk("key_count", 32'(cmd_count), 32'(sb.size()));
  endtask

  // One VS falling edge; optionally a key strobed in the pop cycle.
  task automatic frame(input bit with_key, input logic [7:0] k);
    int ticks;
    bit drop;
    int ox, oy;
    ox = mx;
    oy = my;
    iVS = 1'b0;
    tick();
    chk("ftick_rise", 32'(frame_tick), 32'd1);
    chk("pos_x_hold", 32'(pos_x), 32'(ox));
    chk("pos_y_hold", 32'(pos_y), 32'(oy));
    if (sb.size() > 0) model_apply(sb.pop_front());
    drop = 0;
    if (with_key) begin
      model_key(k, drop);
      key_in = k;
      key_en = 1'b1;
    end
    tick();
    key_en = 1'b0;
    chk("ftick_fall", 32'(frame_tick), 32'd0);
    chk("pos_x", 32'(pos_x), 32'(mx));
    chk("pos_y", 32'(pos_y), 32'(my));
    chk("frame_count", 32'(cmd_count), 32'(sb.size()));
    if (with_key) chk("frame_drop", 32'(cmd_drop), 32'(drop));
    ticks = 0;
    for (int i = 0; i < 3; i++) begin tick(); ticks += int'(frame_tick); end
    iVS = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); ticks += int'(frame_tick); end
    chk("extra_tick", 32'(ticks), 32'd0);
    chk("pos_x_stable", 32'(pos_x), 32'(mx));
    chk("pos_y_stable", 32'(pos_y), 32'(my));
  endtask

  initial begin
    rst    = 1'b1;
    key_in = 8'h00;
    key_en = 1'b0;
    iVS    = 1'b1;
    model_reset();
    tick();
    tick();
    chk("rst_pos_x", 32'(pos_x), 32'd320);
    chk("rst_pos_y", 32'(pos_y), 32'd240);
    chk("rst_count", 32'(cmd_count), 32'd0);
    chk("rst_ftick", 32'(frame_tick), 32'd0);
    chk("rst_drop", 32'(cmd_drop), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 3; i++) frame(0, 8'h00);

    send_key(8'h74);
    send_key(8'h75);
    frame(0, 8'h00);
    chk("after_f1_x", 32'(pos_x), 32'd330);
    frame(0, 8'h00);
    chk("after_f2_y", 32'(pos_y), 32'd230);

    send_key(8'hF0);
    send_key(8'h74);
    send_key(8'hE0);
    send_key(8'hF0);
    send_key(8'h75);
    frame(0, 8'h00);

    for (int i = 0; i < 6; i++) send_key(8'h6B);
    chk("full_count", 32'(cmd_count), 32'd4);
    for (int i = 0; i < 4; i++) frame(0, 8'h00);
    chk("left_x", 32'(pos_x), 32'd290);

    for (int i = 0; i < 4; i++) send_key(8'h74);
    frame(1, 8'h74);
    chk("full_pushpop_count", 32'(cmd_count), 32'd4);
    for (int i = 0; i < 4; i++) frame(0, 8'h00);
    frame(1, 8'h6B);
    chk("no_bypass_count", 32'(cmd_count), 32'd1);
    frame(0, 8'h00);

    for (int i = 0; i < 25; i++) begin
      send_key(8'h72);
      frame(0, 8'h00);
    end
    chk("y_sat_max", 32'(pos_y), 32'd431);

    for (int i = 0; i < 45; i++) begin
      send_key(8'h75);
      frame(0, 8'h00);
    end
    chk("y_sat_min", 32'(pos_y), 32'd0);

    send_key(8'h74);
    send_key(8'h72);
    send_key(8'hF0);
    send_key(8'h6B);
    send_key(8'h6B);
    rst = 1'b1;
    tick();
    model_reset();
    chk("midrst_x", 32'(pos_x), 32'd320);
    chk("midrst_y", 32'(pos_y), 32'd240);
    chk("midrst_count", 32'(cmd_count), 32'd0);
    rst = 1'b0;
    tick();
    frame(0, 8'h00);
    send_key(8'h75);
    frame(0, 8'h00);
    chk("post_rst_up", 32'(pos_y), 32'd230);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
